// File: rtl/flag_unit.sv
// flag_unit: producer of the {S,Z,C,V} FLAG bus for conditional-jump judgement.
// Computes flags from the execute-stage operands. Carries them through a
// LAT-deep writeback pipe, then commits them to the architectural FLAG register.
// Conditional jumps are stalled while any flag update is still in flight.
// Optional feature macro: FLAG_FWD_EN. When defined, FLAG is forwarded from the
// youngest in-flight entry and jmp_stall is tied low.
module flag_unit #(
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_setflag,
  input  logic [1:0]        ex_op,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic              flush,
  input  logic              jmp_req,
  output logic [3:0]        FLAG,
  output logic              flag_busy,
  output logic              jmp_stall
);
  localparam int MSB = DATA_W - 1;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;

  flags_t              ex_flags;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W-1:0]   res_w;
  logic                c_w, v_w;

  logic   [LAT-1:0]    vld_q, vld_d;
  flags_t [LAT-1:0]    stg_q, stg_d;
  flags_t              flag_q, flag_d;

  // Flag arithmetic on the execute-stage operands. The extra top bit of sum_w
  // is the carry for ADD and the borrow (a < b unsigned) for SUB.
  always_comb begin
    sum_w = '0;
    res_w = '0;
    c_w   = 1'b0;
    v_w   = 1'b0;
    case (ex_op)
      OP_ADD: begin
        sum_w = {1'b0, ex_a} + {1'b0, ex_b};
        res_w = sum_w[MSB:0];
        c_w   = sum_w[DATA_W];
        v_w   = (ex_a[MSB] == ex_b[MSB]) && (res_w[MSB] != ex_a[MSB]);
      end
      OP_SUB: begin
        sum_w = {1'b0, ex_a} - {1'b0, ex_b};
        res_w = sum_w[MSB:0];
        c_w   = sum_w[DATA_W];
        v_w   = (ex_a[MSB] != ex_b[MSB]) && (res_w[MSB] != ex_a[MSB]);
      end
      OP_LOGIC: begin
        res_w = ex_a & ex_b;
      end
      default: begin
        res_w = {ex_a[MSB-1:0], 1'b0};
        c_w   = ex_a[MSB];
      end
    endcase
    ex_flags = '{s: res_w[MSB], z: (res_w == '0), c: c_w, v: v_w};
  end

  // Next state: the pipe shifts every cycle. flush squashes every entry,
  // including the one being created and the one about to commit.
  always_comb begin
    vld_d    = '0;
    stg_d    = stg_q;
    flag_d   = flag_q;
    stg_d[0] = ex_flags;
    for (int i = 1; i < LAT; i++) stg_d[i] = stg_q[i-1];
    if (!flush) begin
      vld_d[0] = ex_valid && ex_setflag;
      for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
      if (vld_q[LAT-1]) flag_d = stg_q[LAT-1];
    end
  end

  // State registers; reset discards in-flight entries and clears FLAG.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      stg_q  <= '0;
      flag_q <= '0;
    end else begin
      vld_q  <= vld_d;
      stg_q  <= stg_d;
      flag_q <= flag_d;
    end
  end

  assign flag_busy = |vld_q;

`ifdef FLAG_FWD_EN
  flags_t fwd_w;
  logic   unused_jmp_req;
  assign  unused_jmp_req = jmp_req;

  // Forward the youngest in-flight flags; the lowest valid index wins.
  always_comb begin
    fwd_w = flag_q;
    for (int i = LAT-1; i >= 0; i--) begin
      if (vld_q[i]) fwd_w = stg_q[i];
    end
  end

  assign FLAG      = fwd_w;
  assign jmp_stall = 1'b0;
`else
  assign FLAG      = flag_q;
  assign jmp_stall = jmp_req && flag_busy;
`endif

endmodule
